bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential packed-BCD to binary converter; the reverse direction of the team's combinational binary-to-BCD block.
- Implements reverse double-dabble: shift right one bit per cycle; after each shift, subtract 3 from any BCD digit ≥ 8.
- Sits between BCD sources (keypad/display-side logic) and binary datapaths.
- Ready/valid handshake on both the input and output sides.

Parameters:
- NDIGITS, 3, number of packed BCD digits on the input (input width 4*NDIGITS).
- BIN_W, 10, binary output width; must satisfy 2^BIN_W > 10^NDIGITS − 1 (3 digits → 10 bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the in_bcd value is valid.
- in_ready  output  1  the block can accept a new value (high only in IDLE).
- in_bcd  input  4*NDIGITS  packed BCD; digit 0 is in bits [3:0].
- out_valid  output  1  out_bin holds a finished result.
- out_ready  input  1  the consumer takes the result.
- out_bin  output  BIN_W  binary result.
- out_err  output  1  one or more input digits were > 9 (see Optional Feature).

Behaviour:
- Reset (synchronous, on rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, internal count=0.
  - Reset has priority over all other events, including mid-SHIFT and in DONE; any in-flight conversion is discarded.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load bcd_reg←in_bcd, bin_reg←0, count←0, capture the error flag, go to SHIFT.
- SHIFT (in_ready=0, out_valid=0), each cycle:
  - {bcd_reg, bin_reg} ← {bcd_reg, bin_reg} >> 1, with a 0 shifted in at the MSB.
  - Then, for each digit d of the shifted bcd_reg: d ← (d ≥ 8) ? d − 3 : d. All digits are adjusted in parallel from the shifted value.
  - count ← count+1.
  - The cycle in which count == BIN_W−1 performs the last shift, then the FSM goes to DONE.
- DONE:
  - out_valid=1; out_bin=bin_reg, held stable while out_valid && !out_ready.
  - On out_ready: next state is IDLE, out_valid←0, in_ready←1.
- Latency and throughput:
  - Input accepted at edge k → out_valid first high after edge k+BIN_W (10 cycles at default).
  - One conversion per BIN_W+2 cycles minimum.
  - No input/output overlap; in_ready is 0 from acceptance until the result has been taken.
- in_bcd and in_valid are ignored outside IDLE.
- out_ready is ignored unless out_valid=1.
- Width rule: bin_reg is exactly BIN_W bits. After BIN_W shifts bcd_reg is zero for any legal input.
- Illegal digits (> 9): the conversion still runs BIN_W shifts, and out_bin is the arithmetic result of the algorithm (unspecified value).

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - At acceptance, out_err is registered as the OR over all digits of (digit > 9).
  - out_err is valid together with out_valid and is cleared on the IDLE transition and on reset.
- Undefined: out_err is tied to 0 and no check logic is built.

Decomposition:
- Package bcd2bin_pkg holds:
  - state enum type with IDLE, SHIFT, DONE;
  - DIGIT_W=4 constant;
  - localparam function computing the count width, $clog2(BIN_W).
- One natural sub-module, bcd_digit_adj: 4-bit combinational d ≥ 8 ? d−3 : d. It is instantiated NDIGITS times via generate.

Test Plan:
- Conversion table (each with out_ready=1, out_err=0):
  - in_bcd=12'h000 → out_bin=0 after 10 cycles.
  - in_bcd=12'h999 → out_bin=10'h3E7.
  - in_bcd=12'h255 → out_bin=10'h0FF.
  - in_bcd=12'h128 → out_bin=10'h080.
  - in_bcd=12'h100 → out_bin=10'h064.
- Back-pressure: in_bcd=12'h507 with out_ready=0 for 5 cycles after out_valid → out_bin=10'h1FB held stable, in_ready=0 throughout. Then raise out_ready → out_valid drops and in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 12'h042 then 12'h813 → results 10'h02A then 10'h32D; the second input is accepted only after the first result is taken.
- Reset mid-operation: assert rst at SHIFT cycle 4 → the next cycle shows in_ready=1, out_valid=0 and no result for that input. A following input 12'h064 → 10'h040.
- Illegal digit (macro defined): in_bcd=12'h1A3 → out_err=1 with out_valid. Then 12'h123 → out_err=0, out_bin=10'h07B. With the macro undefined, out_err stays 0.
- Ignored inputs: toggle in_valid/in_bcd during SHIFT → no effect on the in-flight result.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w);
    endfunction

    function automatic logic digit_illegal(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Ready/valid bundle between a BCD producer, the converter and a binary consumer.
interface bcd2bin_seq_if #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   in_bcd;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIN_W-1:0]       out_bin;
    logic                   out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble: subtract 3 from any digit >= 8.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one shift per cycle (reverse double-dabble).
// Optional digit range check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    bcd2bin_seq_if.slave    bus
);

    localparam int BCD_W = DIGIT_W * NDIGITS;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_reg, bcd_nxt;
    logic [BIN_W-1:0]   bin_reg, bin_nxt;
    logic [CNT_W-1:0]   count, count_nxt;

    logic [BCD_W-1:0]   bcd_sh;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_sh;
    logic               accept;
    logic               take;

    // The concatenated {bcd, bin} register shifts right as one word.
    assign bcd_sh = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    for (genvar i = 0; i < NDIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_sh[i*DIGIT_W +: DIGIT_W]),
            .q (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    assign accept      = (state == IDLE) && bus.in_valid;
    assign take        = (state == DONE) && bus.out_ready;
    assign bus.out_bin = bin_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            bcd_reg <= bcd_nxt;
            bin_reg <= bin_nxt;
            count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bcd_nxt       = bcd_reg;
        bin_nxt       = bin_reg;
        count_nxt     = count;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (accept) begin
                    bcd_nxt   = bus.in_bcd;
                    bin_nxt   = '0;
                    count_nxt = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt   = bcd_adj;
                bin_nxt   = bin_sh;
                count_nxt = count + 1'b1;
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (take) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_reg;
    logic digit_err;

    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (digit_illegal(bus.in_bcd[i*DIGIT_W +: DIGIT_W])) begin
                digit_err = 1'b1;
            end
        end
    end

    // The flag is captured with the operand and lives until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= digit_err;
        end else if (take) begin
            err_reg <= 1'b0;
        end
    end

    assign bus.out_err = err_reg;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq: conversion table plus handshake corner cases.
module tb_bcd2bin_seq;

    localparam int NDIGITS = 3;
    localparam int BIN_W   = 10;
    localparam int LAT     = BIN_W;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
        logic        check_bin;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd2bin_seq_if #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin_seq #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic waitResult(output int cycles, input bit toggle);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 50) begin
            if (toggle) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_bcd   = 12'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
    endtask

    // One full conversion with out_ready high; called and returns at a falling edge.
    task automatic applyStimulus(input vec_t v, input bit toggle, input string tag);
        int cycles;
        bus.in_bcd    = v.bcd;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        checkOutput({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        waitResult(cycles, toggle);
        checkOutput({tag, " latency"}, 32'(cycles), 32'(LAT));
        if (v.check_bin) begin
            checkOutput({tag, " out_bin"}, 32'(bus.out_bin), 32'(v.bin));
        end
        checkOutput({tag, " out_err"}, 32'(bus.out_err), 32'(v.err));
        @(negedge clk);
        checkOutput({tag, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   cycles;
        int   seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{12'h000, 10'h000, 1'b0, 1'b1};
        vecs[1] = '{12'h999, 10'h3E7, 1'b0, 1'b1};
        vecs[2] = '{12'h255, 10'h0FF, 1'b0, 1'b1};
        vecs[3] = '{12'h128, 10'h080, 1'b0, 1'b1};
        vecs[4] = '{12'h100, 10'h064, 1'b0, 1'b1};
        vecs[5] = '{12'h1A3, 10'h000, ERR_EN, 1'b0};
        vecs[6] = '{12'h123, 10'h07B, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_bin", 32'(bus.out_bin), 32'd0);
        checkOutput("reset out_err", 32'(bus.out_err), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Ignored inputs: in_valid/in_bcd wiggle during SHIFT must not disturb the result.
        v = '{12'h999, 10'h3E7, 1'b0, 1'b1};
        applyStimulus(v, 1'b1, "toggle");

        // Back-pressure: result held while the consumer stalls.
        bus.in_bcd    = 12'h507;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 0;
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 50) begin
            if (bus.in_ready !== 1'b0) seen++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("bp latency", 32'(cycles), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) seen++;
            checkOutput($sformatf("bp hold out_bin %0d", i), 32'(bus.out_bin), 32'h1FB);
            checkOutput($sformatf("bp hold out_valid %0d", i), 32'(bus.out_valid), 32'd1);
        end
        checkOutput("bp in_ready low throughout", 32'(seen), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp out_valid drop", 32'(bus.out_valid), 32'd0);
        checkOutput("bp in_ready rise", 32'(bus.in_ready), 32'd1);

        // Back-to-back: second operand waits on in_valid until the first result is taken.
        bus.out_ready = 1'b0;
        bus.in_bcd    = 12'h042;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_bcd = 12'h813;
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b first latency", 32'(cycles), 32'(LAT));
        checkOutput("b2b first out_bin", 32'(bus.out_bin), 32'h02A);
        checkOutput("b2b in_ready while held", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("b2b in_ready after take", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        waitResult(cycles, 1'b0);
        checkOutput("b2b second latency", 32'(cycles), 32'(LAT));
        checkOutput("b2b second out_bin", 32'(bus.out_bin), 32'h32D);
        @(negedge clk);

        // Reset mid-SHIFT discards the in-flight conversion.
        bus.in_bcd   = 12'h999;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        checkOutput("midrst no stale result", 32'(seen), 32'd0);
        v = '{12'h064, 10'h040, 1'b0, 1'b1};
        applyStimulus(v, 1'b0, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
